// File: rtl/crypto1_ks_ctrl_if.sv
// Job, Crypto1-core and keystream-byte signals of the Crypto1 keystream controller.
// The controller takes the slave view; whoever drives jobs and models the core takes master.
interface crypto1_ks_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [47:0]      key;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [47:0]      c1_key;
  logic             c1_init;
  logic             c1_stb;
  logic             c1_output;
  logic [7:0]       ks_data;
  logic             ks_valid;
  logic             ks_ready;
  logic             busy;
  logic             done;

  modport slave (
    input  start, key, len, abort, c1_output, ks_ready,
    output c1_key, c1_init, c1_stb, ks_data, ks_valid, busy, done
  );

  modport master (
    output start, key, len, abort, c1_output, ks_ready,
    input  c1_key, c1_init, c1_stb, ks_data, ks_valid, busy, done
  );
endinterface

// File: rtl/crypto1_ks_ctrl.sv
// Sequences a Crypto1 core: loads the key, steps it 8*LEN times, packs the output bits
// into bytes and hands them out over a valid/ready holding register.
module crypto1_ks_ctrl #(
  parameter int unsigned LEN_W     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  crypto1_ks_ctrl_if.slave bus
);
  localparam int unsigned CntW = LEN_W + 3;

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StFin} state_e;

  state_e           state_q, state_d;
  logic [47:0]      key_q;
  logic [LEN_W-1:0] len_q;
  logic [CntW-1:0]  stb_cnt_q, stb_cnt_d;
  logic [CntW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [CntW-1:0]  total;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [6:0]       asm_q, asm_d;
  logic [7:0]       ks_data_q, ks_data_d;
  logic             ks_valid_q, ks_valid_d;
  logic             smp_q;

  logic accept, abort_job, hs, slot_free, stb;

  assign total = {len_q, 3'b000};

  always_comb begin
    accept    = (state_q == StIdle) & bus.start & ~bus.abort;
    abort_job = bus.abort & (state_q != StIdle);
    hs        = ks_valid_q & bus.ks_ready;
    slot_free = ~ks_valid_q | bus.ks_ready;
    // The 8th step of a byte waits until its byte has somewhere to land.
    stb       = (state_q == StRun) & ~bus.abort & (stb_cnt_q != total) &
                ((stb_cnt_q[2:0] != 3'd7) | slot_free);
  end

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StLoad;
      end
      StLoad: begin
        state_d = (len_q != '0) ? StRun : StDrain;
      end
      StRun: begin
        if (stb && ((stb_cnt_q + CntW'(1)) == total)) state_d = StDrain;
      end
      StDrain: begin
        if ((byte_cnt_q == CntW'(len_q)) && !smp_q && slot_free) state_d = StFin;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (abort_job) state_d = StIdle;
  end

  // Bit assembly, byte holding register and counters
  always_comb begin
    stb_cnt_d  = stb_cnt_q;
    byte_cnt_d = byte_cnt_q;
    bit_idx_d  = bit_idx_q;
    asm_d      = asm_q;
    ks_data_d  = ks_data_q;
    ks_valid_d = ks_valid_q;

    if (stb) stb_cnt_d = stb_cnt_q + CntW'(1);
    if (hs) ks_valid_d = 1'b0;

    if (smp_q) begin
      bit_idx_d = bit_idx_q + 3'd1;
      asm_d     = MSB_FIRST ? {asm_q[5:0], bus.c1_output} : {bus.c1_output, asm_q[6:1]};
      if (bit_idx_q == 3'd7) begin
        ks_data_d  = MSB_FIRST ? {asm_q, bus.c1_output} : {bus.c1_output, asm_q};
        ks_valid_d = 1'b1;
        byte_cnt_d = byte_cnt_q + CntW'(1);
      end
    end

    if (accept || abort_job) begin
      stb_cnt_d  = '0;
      byte_cnt_d = '0;
      bit_idx_d  = '0;
      asm_d      = '0;
    end
    if (abort_job) ks_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q      <= '0;
      len_q      <= '0;
      stb_cnt_q  <= '0;
      byte_cnt_q <= '0;
      bit_idx_q  <= '0;
      asm_q      <= '0;
      ks_data_q  <= '0;
      ks_valid_q <= 1'b0;
      smp_q      <= 1'b0;
    end else begin
      if (accept) begin
        key_q <= bus.key;
        len_q <= bus.len;
      end
      stb_cnt_q  <= stb_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      bit_idx_q  <= bit_idx_d;
      asm_q      <= asm_d;
      ks_data_q  <= ks_data_d;
      ks_valid_q <= ks_valid_d;
      // Core output is valid the cycle after a strobe.
      smp_q      <= stb;
    end
  end

  assign bus.c1_key   = key_q;
  assign bus.c1_init  = (state_q == StLoad);
  assign bus.c1_stb   = stb;
  assign bus.ks_data  = ks_data_q;
  assign bus.ks_valid = ks_valid_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StFin) & ~bus.abort;

endmodule

// File: doc/crypto1_ks_ctrl.md
CRYPTO1_KS_CTRL -- requirements
Module: crypto1_ks_ctrl

Interface
REQ-001 SHALL have parameter: LEN_W, 8, width of byte-count request.
REQ-002 SHALL have parameter: MSB_FIRST, 0, 0 = first keystream bit into KS_DATA[0]; 1 = first bit into KS_DATA[7].
REQ-003 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: RESETn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: START  input  1  request a keystream job; sampled only in IDLE.
REQ-006 SHALL have port: KEY  input  48  key for the job; captured on accepted START.
REQ-007 SHALL have port: LEN  input  LEN_W  number of bytes to generate; captured on accepted START.
REQ-008 SHALL have port: ABORT  input  1  cancel the current job.
REQ-009 SHALL have port: C1_KEY  output  48  key to the Crypto1 core; holds the captured KEY.
REQ-010 SHALL have port: C1_INIT  output  1  core load strobe.
REQ-011 SHALL have port: C1_STB  output  1  core step strobe; core output is valid the cycle after each strobe.
REQ-012 SHALL have port: C1_OUTPUT  input  1  core keystream bit.
REQ-013 SHALL have port: KS_DATA  output  8  keystream byte.
REQ-014 SHALL have port: KS_VALID  output  1  KS_DATA valid.
REQ-015 SHALL have port: KS_READY  input  1  consumer accepts byte when KS_VALID & KS_READY.
REQ-016 SHALL have port: BUSY  output  1  high in every state except IDLE.
REQ-017 SHALL have port: DONE  output  1  one-cycle pulse when a job completes normally.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, DRAIN, FIN.
- IDLE -> LOAD on START & ~ABORT.
- LOAD -> RUN (LEN>0) or DRAIN (LEN=0).
- RUN -> DRAIN when all 8*LEN strobes are issued.
- DRAIN -> FIN when the last bit is sampled and the holding register is empty.
- FIN -> IDLE.
REQ-019 SHALL drive C1_INIT high for exactly the one LOAD cycle, with C1_KEY equal to the captured KEY.
REQ-020 SHALL drive C1_STB only in RUN, at most once per cycle, and never in a cycle where ABORT is high.
REQ-021 SHALL sample C1_OUTPUT in the cycle after each C1_STB and shift it into a 7-bit assembly register, bit order per MSB_FIRST.
REQ-022 SHALL, on the 8th sampled bit of a byte, load {assembly, bit} directly into the KS_DATA holding register and set KS_VALID.
REQ-023 SHALL issue the 8th strobe of any byte only if, in that cycle, KS_VALID is low or KS_VALID & KS_READY; otherwise it SHALL stall with no strobe, so data is never overwritten or lost.
REQ-024 SHALL sustain one strobe per cycle when not stalled, giving one byte per 8 cycles.
REQ-025 SHALL clear KS_VALID on a handshake unless a new byte loads on the same edge.
REQ-026 SHALL hold KS_DATA stable while KS_VALID & ~KS_READY.
REQ-027 SHALL handle LEN=0 as: LOAD still issues C1_INIT; no C1_STB; DONE pulses in FIN.
REQ-028 SHALL count strobes and bytes as LEN_W+3 bits, with no wrap below 8*(2^LEN_W-1).
REQ-029 SHALL, on ABORT in any non-IDLE state, go to IDLE at the next edge, clear KS_VALID and the counters, and not pulse DONE.
REQ-030 SHALL let ABORT win over START when both are high in IDLE.
REQ-031 SHALL ignore START while BUSY.
REQ-032 SHALL assert DONE only in FIN, high for exactly one cycle.

Reset
REQ-033 SHALL, while RESETn is low, asynchronously set: state IDLE, C1_INIT=0, C1_STB=0, KS_VALID=0, KS_DATA=0, C1_KEY=0, BUSY=0, DONE=0, counters=0.
REQ-034 SHALL, on reset mid-job, discard the job; after reset release, nothing SHALL be output until a new START.

Verification
REQ-035 SHALL cover nominal timing: START at cycle 0, LEN=1, KS_READY=1 -> C1_INIT cycle 1; C1_STB cycles 2-9; KS_VALID cycle 11 with the byte matching the Crypto1 model bits; DONE cycle 12.
REQ-036 SHALL cover back-pressure: LEN=3 with KS_READY held low for 20 cycles -> exactly 15 strobes issued (8 + 7) before the stall; KS_DATA stable; all 3 bytes correct after release.
REQ-037 SHALL cover LEN=0: one C1_INIT, zero C1_STB, DONE 3 cycles after START.
REQ-038 SHALL cover mid-RUN abort: ABORT in the 5th strobe cycle -> no C1_STB that cycle; IDLE next cycle; KS_VALID=0; no DONE; a following job yields the correct keystream for its new key.
REQ-039 SHALL cover async reset: RESETn low mid-DRAIN -> all outputs at reset values immediately, without waiting for a clock edge.
REQ-040 SHALL cover MSB_FIRST=1 with key 0xA0A1A2A3A4A5: each byte is the bit-reverse of the MSB_FIRST=0 result.
